uart_rx: RTL and testbench

//  UART serial receiver; pairs with the transmitter on the same link config (wls/parity_en/eps/sticky_parity).

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART serial receiver: oversampled start-bit validation, 5-8 data bits LSB first,
// optional parity, first-stop-bit check, and a registered write into the Rxhr.
module uart_rx #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       rxd_i,
    input  logic       parity_en,
    input  logic       sticky_parity,
    input  logic       eps,
    input  logic [1:0] wls,
    input  logic       Rxhr_full,
    output logic [7:0] rx_data_o,
    output logic       Rxhr_wr_en,
    output logic       parity_err,
    output logic       framing_err,
    output logic       break_det,
    output logic       overrun_err,
    output logic       Rxsr_busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SAMP_A    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMP_B    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] SAMP_C    = CW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             samp_q, samp_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             wls_q, wls_d;
    logic                   pen_q, pen_d;
    logic                   eps_q, eps_d;
    logic                   stick_q, stick_d;
    logic                   par_bit_q, par_bit_d;
    logic                   perr_frame_q, perr_frame_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic                   wr_en_q, wr_en_d;
    logic                   ovr_q, ovr_d;

    logic rxd_s;
    logic bit_val;
    logic last_bit;
    logic exp_par;

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign bit_val  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s) | (samp_q[0] & rxd_s);
    assign last_bit = (bit_idx_q == ({1'b0, wls_q} + 3'd4));
    // Upper unused bits of shift_q are cleared at frame start, so full-width reduction is exact.
    assign exp_par  = stick_q ? ~eps_q : (eps_q ? ^shift_q : ~^shift_q);

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], rxd_i};
        samp_d       = samp_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        wls_d        = wls_q;
        pen_d        = pen_q;
        eps_d        = eps_q;
        stick_d      = stick_q;
        par_bit_d    = par_bit_q;
        perr_frame_d = perr_frame_q;
        rx_data_d    = rx_data_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        brk_d        = brk_q;
        wr_en_d      = 1'b0;
        ovr_d        = 1'b0;

        if (baud_tick) begin
            if (state_q != IDLE && state_q != WAIT_IDLE) begin
                tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CW'(1);
                if (tick_cnt_q == SAMP_A) samp_d[1] = rxd_s;
                if (tick_cnt_q == SAMP_B) samp_d[0] = rxd_s;
            end
            case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == SAMP_C) begin
                        if (bit_val) begin
                            state_d    = IDLE;
                            tick_cnt_d = '0;
                        end else begin
                            wls_d        = wls;
                            pen_d        = parity_en;
                            eps_d        = eps;
                            stick_d      = sticky_parity;
                            shift_d      = '0;
                            bit_idx_d    = '0;
                            par_bit_d    = 1'b0;
                            perr_frame_d = 1'b0;
                        end
                    end else if (tick_cnt_q == TICK_LAST) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == SAMP_C) begin
                        shift_d[bit_idx_q] = bit_val;
                    end else if (tick_cnt_q == TICK_LAST) begin
                        if (last_bit) state_d = pen_q ? PARITY : STOP;
                        else          bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == SAMP_C) begin
                        par_bit_d    = bit_val;
                        perr_frame_d = (bit_val != exp_par);
                    end else if (tick_cnt_q == TICK_LAST) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == SAMP_C) begin
                        if (Rxhr_full) begin
                            ovr_d = 1'b1;
                        end else begin
                            wr_en_d   = 1'b1;
                            rx_data_d = shift_q;
                            perr_d    = pen_q & perr_frame_q;
                            ferr_d    = ~bit_val;
                            brk_d     = (shift_q == 8'd0) && !(pen_q && par_bit_q) && !bit_val;
                        end
                        state_d    = bit_val ? IDLE : WAIT_IDLE;
                        tick_cnt_d = '0;
                    end
                end
                WAIT_IDLE: begin
                    if (rxd_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            sync_q       <= '1;
            samp_q       <= '1;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            wls_q        <= '0;
            pen_q        <= 1'b0;
            eps_q        <= 1'b0;
            stick_q      <= 1'b0;
            par_bit_q    <= 1'b0;
            perr_frame_q <= 1'b0;
            rx_data_q    <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            brk_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sync_q       <= sync_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            wls_q        <= wls_d;
            pen_q        <= pen_d;
            eps_q        <= eps_d;
            stick_q      <= stick_d;
            par_bit_q    <= par_bit_d;
            perr_frame_q <= perr_frame_d;
            rx_data_q    <= rx_data_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            brk_q        <= brk_d;
            wr_en_q      <= wr_en_d;
            ovr_q        <= ovr_d;
        end
    end

    assign rx_data_o   = rx_data_q;
    assign Rxhr_wr_en  = wr_en_q;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign break_det   = brk_q;
    assign overrun_err = ovr_q;
    assign Rxsr_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model queue checked every cycle,
// plus literal expectations after directed frames.
module tb_uart_rx;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rxd_i = 1'b1;
    logic       parity_en = 1'b0;
    logic       sticky_parity = 1'b0;
    logic       eps = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       Rxhr_full = 1'b0;
    logic [7:0] rx_data_o;
    logic       Rxhr_wr_en, parity_err, framing_err, break_det, overrun_err, Rxsr_busy;

    localparam int BIT_CLKS = 16 * 6;

    uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .reset(reset), .baud_tick(baud_tick), .rxd_i(rxd_i),
        .parity_en(parity_en), .sticky_parity(sticky_parity), .eps(eps), .wls(wls),
        .Rxhr_full(Rxhr_full), .rx_data_o(rx_data_o), .Rxhr_wr_en(Rxhr_wr_en),
        .parity_err(parity_err), .framing_err(framing_err), .break_det(break_det),
        .overrun_err(overrun_err), .Rxsr_busy(Rxsr_busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            repeat (5) @(posedge sys_clk);
            #1 baud_tick = 1'b1;
            @(posedge sys_clk);
            #1 baud_tick = 1'b0;
        end
    end

    typedef struct {
        bit         ovr;
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    exp_t expq[$];
    exp_t ce;
    logic [7:0] sh_data = '0;
    logic sh_pe = 1'b0, sh_fe = 1'b0, sh_bd = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge sys_clk) begin
        if (reset) begin
            sh_data = '0; sh_pe = 1'b0; sh_fe = 1'b0; sh_bd = 1'b0;
        end else begin
            if (Rxhr_wr_en !== 1'b0 || overrun_err !== 1'b0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_event", {30'd0, Rxhr_wr_en, overrun_err}, 32'd0);
                end else begin
                    ce = expq.pop_front();
                    chk("event_kind", {30'd0, Rxhr_wr_en, overrun_err}, ce.ovr ? 32'd1 : 32'd2);
                    if (!ce.ovr) begin
                        sh_data = ce.data; sh_pe = ce.pe; sh_fe = ce.fe; sh_bd = ce.bd;
                    end
                end
            end
            chk("rx_data", {24'd0, rx_data_o}, {24'd0, sh_data});
            chk("parity_err", {31'd0, parity_err}, {31'd0, sh_pe});
            chk("framing_err", {31'd0, framing_err}, {31'd0, sh_fe});
            chk("break_det", {31'd0, break_det}, {31'd0, sh_bd});
        end
    end

    task automatic drive_bit(input logic b);
        rxd_i = b;
        repeat (BIT_CLKS) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 500; i++) begin
            if (expq.size() == 0) break;
            @(posedge sys_clk);
        end
        #1;
        chk(name, expq.size(), 32'd0);
        expq.delete();
    endtask

    function automatic exp_t model(input logic [7:0] d, input logic [1:0] w, input logic pen,
                                   input logic stk, input logic ep, input logic pbit,
                                   input logic stopb, input logic full);
        exp_t e;
        int unsigned nb;
        logic [7:0] dm;
        logic good;
        nb   = w + 5;
        dm   = d & 8'((1 << nb) - 1);
        good = stk ? ~ep : (ep ? ^dm : ~^dm);
        e.ovr  = full;
        e.data = dm;
        e.pe   = pen && (pbit != good);
        e.fe   = !stopb;
        e.bd   = (dm == 8'd0) && !(pen && pbit) && !stopb;
        return e;
    endfunction

    task automatic send_frame(input string name, input logic [7:0] d, input logic [1:0] w,
                              input logic pen, input logic stk, input logic ep,
                              input logic pbit, input logic stopb, input logic full,
                              input logic scramble);
        int unsigned nb;
        nb = w + 5;
        wls = w; parity_en = pen; sticky_parity = stk; eps = ep; Rxhr_full = full;
        expq.push_back(model(d, w, pen, stk, ep, pbit, stopb, full));
        drive_bit(1'b0);
        if (scramble) begin
            wls = ~w; parity_en = ~pen; sticky_parity = ~stk; eps = ~ep;
        end
        for (int unsigned i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
        drive_bit(1'b1);
        drive_bit(1'b1);
        Rxhr_full = 1'b0;
        wait_drained(name);
    endtask

    task automatic expect_outputs(input string name, input logic [7:0] d, input logic pe,
                                  input logic fe, input logic bd);
        @(negedge sys_clk);
        chk({name, "_data"}, {24'd0, rx_data_o}, {24'd0, d});
        chk({name, "_flags"}, {29'd0, parity_err, framing_err, break_det}, {29'd0, pe, fe, bd});
    endtask

    initial begin
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_outputs", {rx_data_o, Rxhr_wr_en, parity_err, framing_err, break_det,
                              overrun_err, Rxsr_busy}, 32'd0);
        @(posedge sys_clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;

        send_frame("t1_8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_outputs("t1", 8'hA5, 1'b0, 1'b0, 1'b0);

        send_frame("t2_7e1_ok", 8'h5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_outputs("t2a", 8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame("t2_7e1_bad", 8'h5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_outputs("t2b", 8'h5A, 1'b1, 1'b0, 1'b0);

        send_frame("t3_5s_ok", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_outputs("t3a", 8'h1F, 1'b0, 1'b0, 1'b0);
        send_frame("t3_5s_bad", 8'h1F, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_outputs("t3b", 8'h1F, 1'b1, 1'b0, 1'b0);

        send_frame("t_6o1", 8'h2B, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_outputs("t6o1", 8'h2B, 1'b0, 1'b0, 1'b0);

        send_frame("t_ferr", 8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_outputs("tferr", 8'h81, 1'b0, 1'b1, 1'b0);

        // config inputs flipped right after the start bit must not affect this frame
        send_frame("t_scramble", 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_outputs("tscr", 8'h96, 1'b0, 1'b0, 1'b0);
        wls = 2'b11; parity_en = 1'b0; sticky_parity = 1'b0; eps = 1'b0;

        rxd_i = 1'b0;
        repeat (24) @(posedge sys_clk);
        #1 rxd_i = 1'b1;
        @(negedge sys_clk);
        chk("glitch_busy_seen", {31'd0, Rxsr_busy}, 32'd1);
        repeat (16 * 6) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("glitch_busy_clear", {31'd0, Rxsr_busy}, 32'd0);
        wait_drained("glitch_no_write");

        expq.push_back(model(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 12; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        wait_drained("t5_break");
        expect_outputs("t5brk", 8'h00, 1'b0, 1'b1, 1'b1);
        send_frame("t5_after", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_outputs("t5clean", 8'h3C, 1'b0, 1'b0, 1'b0);

        send_frame("t6_overrun", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_outputs("t6keep", 8'h3C, 1'b0, 1'b0, 1'b0);

        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b1;
        rxd_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("midreset_outputs", {rx_data_o, Rxhr_wr_en, parity_err, framing_err, break_det,
                                 overrun_err, Rxsr_busy}, 32'd0);
        @(posedge sys_clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) drive_bit(1'b1);
        @(negedge sys_clk);
        chk("midreset_idle", {rx_data_o, Rxhr_wr_en, Rxsr_busy}, 32'd0);
        wait_drained("midreset_no_write");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end

endmodule
